alu_cmd_driver: RTL and testbench

- Initiator-side sequencer for the fixed-point ALU; sits between a host command stream and the ALU handshake.
- Buffers host commands, issues them to the ALU one at a time while respecting busy, and captures each ALU result.
- Returns results to the host in order through a result FIFO, tagged with the opcode.
- Detects a missing ALU response with a timeout and returns an error-flagged result instead.

---
 rtl/alu_cmd_driver_if.sv | 60 ++++++
 rtl/alu_cmd_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_driver_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_driver_if
//  Purpose  : Bundles the host command stream, the ALU handshake and the
//             result stream seen by alu_cmd_driver.
//  Ports    : none (interface); parameters INST_W / DATA_W size the opcode
//             and data fields.
//             modport master - the driver itself (drives o_* signals)
//             modport slave  - the environment: host + ALU (drives i_* signals)
//  Revision : 1.0  initial release
// ============================================================================
interface alu_cmd_driver_if #(
  parameter int INST_W = 4,
  parameter int DATA_W = 16
);
  // host command side
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [INST_W-1:0] i_cmd_inst;
  logic [DATA_W-1:0] i_cmd_a;
  logic [DATA_W-1:0] i_cmd_b;
  // ALU request side
  logic              o_alu_valid;
  logic              i_alu_busy;
  logic [INST_W-1:0] o_alu_inst;
  logic [DATA_W-1:0] o_alu_data_a;
  logic [DATA_W-1:0] o_alu_data_b;
  // ALU response side
  logic              i_alu_out_valid;
  logic [DATA_W-1:0] i_alu_data;
  // host result side
  logic              o_res_valid;
  logic              i_res_ready;
  logic [INST_W-1:0] o_res_inst;
  logic [DATA_W-1:0] o_res_data;
  logic              o_res_err;
  // status
  logic              o_idle;

  modport master (
    input  i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b,
    output o_cmd_ready,
    output o_alu_valid, o_alu_inst, o_alu_data_a, o_alu_data_b,
    input  i_alu_busy, i_alu_out_valid, i_alu_data,
    output o_res_valid, o_res_inst, o_res_data, o_res_err,
    input  i_res_ready,
    output o_idle
  );

  modport slave (
    output i_cmd_valid, i_cmd_inst, i_cmd_a, i_cmd_b,
    input  o_cmd_ready,
    input  o_alu_valid, o_alu_inst, o_alu_data_a, o_alu_data_b,
    output i_alu_busy, i_alu_out_valid, i_alu_data,
    input  o_res_valid, o_res_inst, o_res_data, o_res_err,
    output i_res_ready,
    input  o_idle
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_driver
//  Purpose  : Initiator-side sequencer for the fixed-point ALU. Buffers host
//             commands, issues them one at a time while honouring ALU busy,
//             captures each response (or a timeout error) and returns the
//             results in order, tagged with the opcode.
//  Ports    : i_clk    - clock, rising edge
//             i_rst_n  - asynchronous active-low reset
//             bus      - alu_cmd_driver_if.master carrying
//                        cmd  : i_cmd_valid/o_cmd_ready/i_cmd_inst/a/b
//                        alu  : o_alu_valid/i_alu_busy/o_alu_inst/data_a/b,
//                               i_alu_out_valid/i_alu_data
//                        res  : o_res_valid/i_res_ready/o_res_inst/data/err
//                        o_idle
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_driver #(
  parameter int INST_W    = 4,
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_cmd_driver_if.master     bus
);

  localparam int CW = $clog2(CMD_DEPTH);
  localparam int RW = $clog2(RES_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [CW:0]   c_CMD_FULL = (CW+1)'(CMD_DEPTH);
  localparam logic [RW+1:0] c_RES_LIM  = (RW+2)'(RES_DEPTH);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;

  logic [INST_W-1:0] alu_inst_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;

  logic [INST_W-1:0] cmd_inst_mem_q [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_a_mem_q    [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_b_mem_q    [CMD_DEPTH];
  logic [CW-1:0]     cmd_wr_ptr_q, cmd_rd_ptr_q;
  logic [CW:0]       cmd_count_q, cmd_count_d;

  logic [INST_W-1:0] res_inst_mem_q [RES_DEPTH];
  logic [DATA_W-1:0] res_data_mem_q [RES_DEPTH];
  logic              res_err_mem_q  [RES_DEPTH];
  logic [RW-1:0]     res_wr_ptr_q, res_rd_ptr_q;
  logic [RW:0]       res_count_q, res_count_d;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic              w_cmd_push, w_cmd_pop, w_cmd_empty;
  logic              w_res_push, w_res_pop;
  logic              w_timeout_hit;
  logic [DATA_W-1:0] w_res_data_in;
  logic              w_res_err_in;
  logic [RW+1:0]     w_res_sum;
  logic              w_elig;
  logic              w_load_cmd;
  logic              w_alu_valid;

  assign w_cmd_empty = (cmd_count_q == '0);
  assign w_cmd_push  = bus.i_cmd_valid && bus.o_cmd_ready;

  // The last WAIT cycle without a response produces an error result instead.
  assign w_timeout_hit = (state_q == S_WAIT) && !bus.i_alu_out_valid &&
                         (tmo_cnt_q == c_TMO_LAST);
  // Responses outside WAIT are stale (after timeout or reset) and dropped.
  assign w_res_push    = (state_q == S_WAIT) && (bus.i_alu_out_valid || w_timeout_hit);
  assign w_res_data_in = bus.i_alu_out_valid ? bus.i_alu_data : '0;
  assign w_res_err_in  = !bus.i_alu_out_valid;
  assign w_res_pop     = bus.o_res_valid && bus.i_res_ready;

  // A result slot is reserved at issue time, so the result FIFO can never
  // overflow. A same-cycle pop is intentionally not credited, which keeps
  // the eligibility path free of the host's i_res_ready.
  assign w_res_sum = {1'b0, res_count_q} + {{(RW+1){1'b0}}, w_res_push};
  assign w_elig    = !w_cmd_empty && !bus.i_alu_busy && (w_res_sum < c_RES_LIM);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_elig) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (w_res_push) state_d = w_elig ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_alu_valid = 1'b0;
    w_cmd_pop   = 1'b0;
    w_load_cmd  = 1'b0;
    tmo_cnt_d   = '0;
    case (state_q)
      S_IDLE: w_load_cmd = w_elig;
      S_ISSUE: begin
        w_alu_valid = 1'b1;
        w_cmd_pop   = 1'b1;
      end
      S_WAIT: begin
        tmo_cnt_d  = tmo_cnt_q + TW'(1);
        w_load_cmd = w_res_push && w_elig;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // ALU request registers: loaded one cycle ahead of ISSUE so that the
  // operands are stable while o_alu_valid is high; they keep the last issued
  // command afterwards, which also supplies the opcode tag for the result.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_inst_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else if (w_load_cmd) begin
      alu_inst_q <= cmd_inst_mem_q[cmd_rd_ptr_q];
      alu_a_q    <= cmd_a_mem_q[cmd_rd_ptr_q];
      alu_b_q    <= cmd_b_mem_q[cmd_rd_ptr_q];
    end
  end

  // --------------------------------------------------------------------------
  // Command FIFO. Only ISSUE pops, and the head it pops is the entry that was
  // loaded into the request registers on the way in.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_cmd_push) begin
      cmd_inst_mem_q[cmd_wr_ptr_q] <= bus.i_cmd_inst;
      cmd_a_mem_q[cmd_wr_ptr_q]    <= bus.i_cmd_a;
      cmd_b_mem_q[cmd_wr_ptr_q]    <= bus.i_cmd_b;
    end
  end

  always_comb begin
    cmd_count_d = cmd_count_q;
    case ({w_cmd_push, w_cmd_pop})
      2'b10:   cmd_count_d = cmd_count_q + (CW+1)'(1);
      2'b01:   cmd_count_d = cmd_count_q - (CW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd_wr_ptr_q <= '0;
      cmd_rd_ptr_q <= '0;
      cmd_count_q  <= '0;
    end else begin
      if (w_cmd_push) cmd_wr_ptr_q <= cmd_wr_ptr_q + CW'(1);
      if (w_cmd_pop)  cmd_rd_ptr_q <= cmd_rd_ptr_q + CW'(1);
      cmd_count_q <= cmd_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Result FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_res_push) begin
      res_inst_mem_q[res_wr_ptr_q] <= alu_inst_q;
      res_data_mem_q[res_wr_ptr_q] <= w_res_data_in;
      res_err_mem_q[res_wr_ptr_q]  <= w_res_err_in;
    end
  end

  always_comb begin
    res_count_d = res_count_q;
    case ({w_res_push, w_res_pop})
      2'b10:   res_count_d = res_count_q + (RW+1)'(1);
      2'b01:   res_count_d = res_count_q - (RW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_wr_ptr_q <= '0;
      res_rd_ptr_q <= '0;
      res_count_q  <= '0;
    end else begin
      if (w_res_push) res_wr_ptr_q <= res_wr_ptr_q + RW'(1);
      if (w_res_pop)  res_rd_ptr_q <= res_rd_ptr_q + RW'(1);
      res_count_q <= res_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Result fields are gated with valid so that the un-reset storage
  // never shows through while the FIFO is empty.
  // --------------------------------------------------------------------------
  assign bus.o_cmd_ready  = (cmd_count_q != c_CMD_FULL);
  assign bus.o_alu_valid  = w_alu_valid;
  assign bus.o_alu_inst   = alu_inst_q;
  assign bus.o_alu_data_a = alu_a_q;
  assign bus.o_alu_data_b = alu_b_q;
  assign bus.o_res_valid  = (res_count_q != '0);
  assign bus.o_res_inst   = bus.o_res_valid ? res_inst_mem_q[res_rd_ptr_q] : '0;
  assign bus.o_res_data   = bus.o_res_valid ? res_data_mem_q[res_rd_ptr_q] : '0;
  assign bus.o_res_err    = bus.o_res_valid ? res_err_mem_q[res_rd_ptr_q]  : 1'b0;
  assign bus.o_idle       = (state_q == S_IDLE) && w_cmd_empty && (res_count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_alu_cmd_driver
//  Purpose  : Directed self-checking bench for alu_cmd_driver with a
//             two-cycle-latency ALU stand-in that returns a + b.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_driver_if #(.INST_W(4), .DATA_W(16)) bus ();

  alu_cmd_driver #(
    .INST_W(4), .DATA_W(16), .CMD_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ALU stand-in: answers 2 cycles after o_alu_valid when resp_en is set;
  // inj_* lets the sequence force an unsolicited response.
  logic        resp_en   = 1'b1;
  logic        inj_valid = 1'b0;
  logic [15:0] inj_data  = '0;
  logic        p1 = 1'b0, p2 = 1'b0;
  logic [15:0] d1 = '0, d2 = '0;
  always @(posedge clk) begin
    p1 <= bus.o_alu_valid && resp_en;
    d1 <= bus.o_alu_data_a + bus.o_alu_data_b;
    p2 <= p1;
    d2 <= d1;
  end
  assign bus.i_alu_out_valid = p2 | inj_valid;
  assign bus.i_alu_data      = p2 ? d2 : inj_data;

  // Issue / back-pressure monitor
  int cyc = 0, issues = 0, last_issue = 0, last_gap = 0, not_ready_cycles = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_alu_valid) begin
      issues     <= issues + 1;
      last_gap   <= cyc - last_issue;
      last_issue <= cyc;
    end
    if (!bus.o_cmd_ready) not_ready_cycles <= not_ready_cycles + 1;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] inst, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_inst  = inst;
    bus.i_cmd_a     = a;
    bus.i_cmd_b     = b;
    while (!bus.o_cmd_ready && guard < 100) begin tick(); guard++; end
    check("push_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    tick();
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] inst,
                            input logic [15:0] data, input logic err);
    int guard = 0;
    while (!bus.o_res_valid && guard < 100) begin tick(); guard++; end
    check({tag, "_valid"}, {31'd0, bus.o_res_valid}, 32'd1);
    check({tag, "_inst"},  {28'd0, bus.o_res_inst},  {28'd0, inst});
    check({tag, "_data"},  {16'd0, bus.o_res_data},  {16'd0, data});
    check({tag, "_err"},   {31'd0, bus.o_res_err},   {31'd0, err});
    bus.i_res_ready = 1'b1;
    tick();
    bus.i_res_ready = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int guard = 0;
    while (!bus.o_alu_valid && guard < 100) begin tick(); guard++; end
    check({tag, "_issue"}, {31'd0, bus.o_alu_valid}, 32'd1);
  endtask

  initial begin
    int i0, nr0;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_inst  = '0;
    bus.i_cmd_a     = '0;
    bus.i_cmd_b     = '0;
    bus.i_alu_busy  = 1'b0;
    bus.i_res_ready = 1'b0;

    // ---------------- reset values ----------------
    tick(2);
    check("rst_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    check("rst_res_valid", {31'd0, bus.o_res_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    check("rst_idle",      {31'd0, bus.o_idle},      32'd1);
    check("rst_data_a",    {16'd0, bus.o_alu_data_a}, 32'd0);
    check("rst_res_data",  {16'd0, bus.o_res_data},  32'd0);
    rst_n = 1'b1;
    tick();

    // ---------------- single op latency ----------------
    bus.i_cmd_valid = 1'b1;                // cycle 0
    bus.i_cmd_inst  = 4'h0;
    bus.i_cmd_a     = 16'h0400;
    bus.i_cmd_b     = 16'h0C00;
    tick();                                // cycle 1
    bus.i_cmd_valid = 1'b0;
    check("single_c1_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    tick();                                // cycle 2
    check("single_c2_alu_valid", {31'd0, bus.o_alu_valid}, 32'd1);
    check("single_c2_alu_a",     {16'd0, bus.o_alu_data_a}, 32'h0400);
    tick();                                // cycle 3
    check("single_c3_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    tick();                                // cycle 4
    check("single_c4_res_valid", {31'd0, bus.o_res_valid}, 32'd0);
    tick();                                // cycle 5
    check("single_c5_res_valid", {31'd0, bus.o_res_valid}, 32'd1);
    pop_expect("single", 4'h0, 16'h1000, 1'b0);
    check("single_idle", {31'd0, bus.o_idle}, 32'd1);

    // ---------------- result back-pressure ----------------
    i0  = issues;
    nr0 = not_ready_cycles;
    for (int k = 0; k < 6; k++) push(4'h2, 16'(16'h0100 * (k + 1)), 16'h0001);
    tick(20);
    check("bp_issues_held", issues - i0, 32'd4);
    check("bp_cmd_full_seen", {31'd0, (not_ready_cycles - nr0) != 0}, 32'd1);
    check("bp_alu_valid_held", {31'd0, bus.o_alu_valid}, 32'd0);
    for (int k = 0; k < 6; k++)
      pop_expect("bp", 4'h2, 16'(16'h0100 * (k + 1) + 1), 1'b0);
    tick(5);
    check("bp_issues_all", issues - i0, 32'd6);
    check("bp_idle", {31'd0, bus.o_idle}, 32'd1);

    // ---------------- busy hold ----------------
    bus.i_alu_busy = 1'b1;
    i0 = issues;
    push(4'h1, 16'h0010, 16'h0020);
    push(4'h3, 16'h0030, 16'h0040);
    tick(6);
    check("busy_no_issue", issues - i0, 32'd0);
    bus.i_alu_busy = 1'b0;                 // cycle T
    check("busy_T_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    tick();                                // T+1
    check("busy_T1_alu_valid", {31'd0, bus.o_alu_valid}, 32'd1);
    check("busy_T1_alu_inst",  {28'd0, bus.o_alu_inst}, 32'h1);
    tick(3);                               // T+4
    check("busy_T4_alu_valid", {31'd0, bus.o_alu_valid}, 32'd1);
    tick();
    check("busy_gap", last_gap, 32'd3);
    pop_expect("busy0", 4'h1, 16'h0030, 1'b0);
    pop_expect("busy1", 4'h3, 16'h0070, 1'b0);

    // ---------------- timeout ----------------
    resp_en = 1'b0;
    push(4'h5, 16'h1111, 16'h2222);
    wait_issue("tmo");                     // cycle I
    tick(8);                               // I+8: last WAIT cycle
    check("tmo_early_res_valid", {31'd0, bus.o_res_valid}, 32'd0);
    tick();                                // I+9
    check("tmo_res_valid", {31'd0, bus.o_res_valid}, 32'd1);
    tick();                                // I+10: stale response
    inj_valid = 1'b1;
    inj_data  = 16'hBEEF;
    tick();
    inj_valid = 1'b0;
    tick(3);
    pop_expect("tmo", 4'h5, 16'h0000, 1'b1);
    check("tmo_late_ignored", {31'd0, bus.o_res_valid}, 32'd0);
    check("tmo_idle", {31'd0, bus.o_idle}, 32'd1);

    // ---------------- reset mid-WAIT ----------------
    push(4'h6, 16'h0A0A, 16'h0505);
    push(4'h7, 16'h0001, 16'h0002);
    wait_issue("rstw");
    tick();                                // first WAIT cycle
    rst_n = 1'b0;
    #1;
    check("rstw_alu_valid", {31'd0, bus.o_alu_valid}, 32'd0);
    check("rstw_res_valid", {31'd0, bus.o_res_valid}, 32'd0);
    check("rstw_cmd_ready", {31'd0, bus.o_cmd_ready}, 32'd1);
    check("rstw_idle",      {31'd0, bus.o_idle},      32'd1);
    check("rstw_data_a",    {16'd0, bus.o_alu_data_a}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    inj_valid = 1'b1;
    inj_data  = 16'h1234;
    tick();
    inj_valid = 1'b0;
    tick(3);
    check("rstw_no_result", {31'd0, bus.o_res_valid}, 32'd0);
    check("rstw_idle_after", {31'd0, bus.o_idle}, 32'd1);
    check("rstw_no_issue_after", {31'd0, bus.o_alu_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
